// File: rtl/axi_lite_burst_ctrl_if.sv
// axi_lite_burst_ctrl_if: AXI4-Lite channel bundle between the burst controller and the interconnect
interface axi_lite_burst_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bvalid, arready, rdata, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bvalid, arready, rdata, rvalid
  );
endinterface

// File: rtl/axi_lite_burst_ctrl.sv
// axi_lite_burst_ctrl: moves cache lines as BEATS single-beat AXI4-Lite transfers, write-back before refill
module axi_lite_burst_ctrl #(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int BEATS  = 16,
  localparam int BW     = $clog2(BEATS),
  localparam int OB     = $clog2(DATA_W/8)
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic              i_wb_req,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [BW-1:0]     o_wb_beat,
  output logic              o_wb_done,
  input  logic              i_rf_req,
  input  logic [ADDR_W-1:0] i_rf_addr,
  output logic [DATA_W-1:0] o_rf_data,
  output logic [BW-1:0]     o_rf_beat,
  output logic              o_rf_valid,
  output logic              o_rf_done,
  output logic              o_axi_free,
  axi_lite_burst_ctrl_if.master axi
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE} state_t;
  state_t                   state_q, state_d;
  logic [ADDR_W-BW-OB-1:0]  base_q, base_d;
  logic [BW-1:0]            beat_q, beat_d;
  logic                     is_wr_q, is_wr_d;
  logic                     aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [DATA_W-1:0]        rf_data_q;
  logic [BW-1:0]            rf_beat_q;
  logic                     rf_valid_q;
  logic                     aw_fire, w_fire, last, r_take;
  logic [ADDR_W-1:0]        beat_addr;
  logic                     unused_low;
  assign unused_low = ^{i_wb_addr[BW+OB-1:0], i_rf_addr[BW+OB-1:0]};
  // beat index replaces the line offset, so increments never carry into the base
  assign beat_addr   = {base_q, beat_q, {OB{1'b0}}};
  assign last        = beat_q == BW'(BEATS-1);
  assign aw_fire     = axi.awvalid && axi.awready;
  assign w_fire      = axi.wvalid && axi.wready;
  assign r_take      = state_q == RD_DATA && axi.rvalid;
  assign axi.awaddr  = beat_addr;
  assign axi.araddr  = beat_addr;
  assign axi.wdata   = i_wb_data;
  assign axi.wstrb   = '1;
  assign axi.awvalid = state_q == WR_REQ && !aw_done_q;
  assign axi.wvalid  = state_q == WR_REQ && !w_done_q;
  assign axi.bready  = state_q == WR_RESP;
  assign axi.arvalid = state_q == RD_REQ;
  assign axi.rready  = state_q == RD_DATA;
  assign o_wb_beat   = beat_q;
  assign o_wb_done   = state_q == DONE && is_wr_q;
  assign o_rf_done   = state_q == DONE && !is_wr_q;
  assign o_axi_free  = state_q == IDLE;
  assign o_rf_data   = rf_data_q;
  assign o_rf_beat   = rf_beat_q;
  assign o_rf_valid  = rf_valid_q;
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    beat_d    = beat_q;
    is_wr_d   = is_wr_q;
    aw_done_d = 1'b0;
    w_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_wb_req || i_rf_req) begin
          state_d = i_wb_req ? WR_REQ : RD_REQ;
          base_d  = i_wb_req ? i_wb_addr[ADDR_W-1:BW+OB] : i_rf_addr[ADDR_W-1:BW+OB];
          beat_d  = '0;
          is_wr_d = i_wb_req;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_done_q || aw_fire;
        w_done_d  = w_done_q || w_fire;
        if (aw_done_d && w_done_d) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: begin
        if (axi.bvalid) begin
          state_d = last ? DONE : WR_REQ;
          beat_d  = last ? beat_q : beat_q + 1'b1;
        end
      end
      RD_REQ:  state_d = axi.arready ? RD_DATA : RD_REQ;
      RD_DATA: begin
        if (axi.rvalid) begin
          state_d = last ? DONE : RD_REQ;
          beat_d  = last ? beat_q : beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      beat_q     <= '0;
      is_wr_q    <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rf_data_q  <= '0;
      rf_beat_q  <= '0;
      rf_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      beat_q     <= beat_d;
      is_wr_q    <= is_wr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rf_valid_q <= r_take;
      if (r_take) begin
        rf_data_q <= axi.rdata;
        rf_beat_q <= beat_q;
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_burst_ctrl.sv
// tb_axi_lite_burst_ctrl: scoreboard bench with a stalling AXI4-Lite slave model
module tb_axi_lite_burst_ctrl;
  localparam int AW = 32, DW = 32, BEATS = 16;
  logic        clk = 1'b0, arst = 1'b1;
  logic        wb_req = 1'b0, rf_req = 1'b0;
  logic [31:0] wb_addr = '0, rf_addr = '0, wb_data, rf_data;
  logic [3:0]  wb_beat, rf_beat;
  logic        wb_done, rf_done, rf_valid, axi_free;
  always #5 clk = ~clk;
  axi_lite_burst_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();
  axi_lite_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BEATS(BEATS)) dut (
    .i_clk(clk), .i_arst(arst),
    .i_wb_req(wb_req), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_wb_beat(wb_beat), .o_wb_done(wb_done),
    .i_rf_req(rf_req), .i_rf_addr(rf_addr), .o_rf_data(rf_data), .o_rf_beat(rf_beat),
    .o_rf_valid(rf_valid), .o_rf_done(rf_done), .o_axi_free(axi_free), .axi(axi)
  );
  function automatic logic [31:0] wdat(logic [31:0] base, int k);
    return {base[31:16], 8'hD0, 4'h0, 4'(k)};
  endfunction
  function automatic logic [31:0] rword(logic [31:0] a);
    return ~a ^ 32'h1234_5678;
  endfunction
  assign wb_data = wdat(wb_addr, int'(wb_beat));
  int checks = 0, failures = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  logic [31:0] q_aw[$], q_w[$], q_ar[$];
  logic [35:0] q_rf[$];
  task automatic push_wb(logic [31:0] base);
    for (int k = 0; k < BEATS; k++) begin
      q_aw.push_back({base[31:6], 6'b0} + 32'(4 * k));
      q_w.push_back(wdat(base, k));
    end
  endtask
  task automatic push_rf(logic [31:0] base);
    for (int k = 0; k < BEATS; k++) begin
      q_ar.push_back({base[31:6], 6'b0} + 32'(4 * k));
      q_rf.push_back({4'(k), rword({base[31:6], 6'b0} + 32'(4 * k))});
    end
  endtask
  int  dly_aw = 0, dly_w = 0, dly_b = 0, dly_ar = 0, dly_r = 0;
  bit  rnd = 0;
  int  aw_wt, w_wt, b_wt, ar_wt, r_wt;
  bit  aw_got, w_got, b_pend, r_pend;
  bit  f_aw, f_w, f_b, f_ar, f_r, r_fire_prev, hold_aw, hold_w, hold_ar;
  logic [31:0] r_addr, p_awaddr, p_wdata, p_araddr;
  int  aw_hi = 0, w_hi = 0, ar_fires = 0, rf_cnt = 0, wb_done_cnt = 0, rf_done_cnt = 0;
  function automatic int stall(int d);
    return rnd ? int'($urandom_range(0, 5)) : d;
  endfunction
  // slave drives at the falling edge, then the monitor samples 1 ns later
  initial begin
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.arready = 0; axi.rvalid = 0; axi.rdata = '0;
    forever begin
      @(negedge clk);
      if (arst) begin
        {aw_got, w_got, b_pend, r_pend, f_aw, f_w, f_b, f_ar, f_r} = '0;
        {r_fire_prev, hold_aw, hold_w, hold_ar} = '0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.arready = 0; axi.rvalid = 0;
        aw_wt = stall(dly_aw); w_wt = stall(dly_w); ar_wt = stall(dly_ar);
        continue;
      end
      if (f_b) b_pend = 0;
      if (f_r) r_pend = 0;
      if (f_aw) begin aw_got = 1; aw_wt = stall(dly_aw); end
      if (f_w) begin w_got = 1; w_wt = stall(dly_w); end
      if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_wt = stall(dly_b); end
      if (f_ar) begin r_pend = 1; r_wt = stall(dly_r); ar_wt = stall(dly_ar); end
      axi.awready = axi.awvalid && aw_wt == 0;
      if (axi.awvalid && aw_wt > 0) aw_wt--;
      axi.wready = axi.wvalid && w_wt == 0;
      if (axi.wvalid && w_wt > 0) w_wt--;
      axi.arready = axi.arvalid && ar_wt == 0;
      if (axi.arvalid && ar_wt > 0) ar_wt--;
      axi.bvalid = b_pend && b_wt == 0;
      if (b_pend && b_wt > 0) b_wt--;
      axi.rvalid = r_pend && r_wt == 0;
      axi.rdata  = r_pend ? rword(r_addr) : '0;
      if (r_pend && r_wt > 0) r_wt--;
      #1;
      if (arst) continue;
      f_aw = axi.awvalid && axi.awready;
      f_w  = axi.wvalid && axi.wready;
      f_b  = axi.bvalid && axi.bready;
      f_ar = axi.arvalid && axi.arready;
      f_r  = axi.rvalid && axi.rready;
      if (axi.awvalid) aw_hi++;
      if (axi.wvalid) w_hi++;
      if (axi.awvalid || axi.wvalid || axi.bready || axi.arvalid || axi.rready)
        chk("chan_excl", (axi.awvalid || axi.wvalid || axi.bready) && (axi.arvalid || axi.rready), 0);
      if (hold_aw) chk("aw_stable", {axi.awvalid, axi.awaddr}, {1'b1, p_awaddr});
      if (hold_w) chk("w_stable", {axi.wvalid, axi.wdata}, {1'b1, p_wdata});
      if (hold_ar) chk("ar_stable", {axi.arvalid, axi.araddr}, {1'b1, p_araddr});
      hold_aw = axi.awvalid && !f_aw; p_awaddr = axi.awaddr;
      hold_w  = axi.wvalid && !f_w;   p_wdata  = axi.wdata;
      hold_ar = axi.arvalid && !f_ar; p_araddr = axi.araddr;
      if (f_aw) begin
        if (q_aw.size() == 0) chk("aw_unexpected", 1, 0);
        else chk("awaddr", axi.awaddr, q_aw.pop_front());
      end
      if (f_w) begin
        chk("wstrb", axi.wstrb, 4'hF);
        if (q_w.size() == 0) chk("w_unexpected", 1, 0);
        else chk("wdata", axi.wdata, q_w.pop_front());
      end
      if (f_ar) begin
        ar_fires++;
        r_addr = axi.araddr;
        if (q_ar.size() == 0) chk("ar_unexpected", 1, 0);
        else chk("araddr", axi.araddr, q_ar.pop_front());
      end
      if (rf_valid || r_fire_prev) chk("rf_valid_timing", rf_valid, r_fire_prev);
      if (rf_valid) begin
        rf_cnt++;
        if (q_rf.size() == 0) chk("rf_unexpected", 1, 0);
        else chk("rf_beat_data", {rf_beat, rf_data}, q_rf.pop_front());
      end
      r_fire_prev = f_r;
      if (wb_done) wb_done_cnt++;
      if (rf_done) rf_done_cnt++;
      if (wb_done || rf_done) chk("done_excl", wb_done && rf_done, 0);
    end
  end
  task automatic wait_done(input bit wr, output int cyc);
    cyc = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      cyc++;
      #2;
      if (wr ? wb_done : rf_done) return;
    end
    chk("done_timeout", 1, 0);
  endtask
  task automatic idle(int n);
    repeat (n) @(negedge clk);
    #2;
  endtask
  int cyc, ar0, r0, wd0, rd0;
  initial begin
    idle(3);
    chk("rst_free", axi_free, 1);
    chk("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    chk("rst_outs", {wb_done, rf_done, rf_valid, rf_data}, 0);
    arst = 0;
    idle(2);
    // zero-wait refill, done on cycle 1 + 2*16 + 1
    push_rf(32'h1000_0000); rf_addr = 32'h1000_0000; rf_req = 1;
    wait_done(0, cyc); rf_req = 0;
    chk("rf_done_cycle", cyc, 34);
    idle(2);
    chk("rf1_drained", q_ar.size() + q_rf.size(), 0);
    chk("rf1_done_cnt", rf_done_cnt, 1);
    // write-back with AW ready 3 cycles late
    dly_aw = 3; aw_hi = 0; w_hi = 0; aw_wt = 3;
    push_wb(32'h2000_0040); wb_addr = 32'h2000_0040; wb_req = 1;
    wait_done(1, cyc); wb_req = 0;
    idle(2);
    chk("wb_awvalid_cycles", aw_hi, 4 * BEATS);
    chk("wb_wvalid_cycles", w_hi, BEATS);
    chk("wb_drained", q_aw.size() + q_w.size(), 0);
    chk("wb_done_cnt", wb_done_cnt, 1);
    dly_aw = 0; aw_wt = 0;
    // simultaneous requests: write-back wins
    push_wb(32'h4000_0080); push_rf(32'h5000_0100);
    wb_addr = 32'h4000_0080; rf_addr = 32'h5000_0100; ar0 = ar_fires;
    wb_req = 1; rf_req = 1;
    wait_done(1, cyc); wb_req = 0;
    chk("rf_held_off", ar_fires - ar0, 0);
    chk("wb_first_drained", q_aw.size() + q_w.size(), 0);
    wait_done(0, cyc); rf_req = 0;
    idle(2);
    chk("both_drained", q_ar.size() + q_rf.size(), 0);
    chk("both_done_cnt", {wb_done_cnt, rf_done_cnt}, {32'd2, 32'd2});
    // unaligned base ignores line offset bits
    push_rf(32'h3000_0017); rf_addr = 32'h3000_0017; rf_req = 1;
    wait_done(0, cyc); rf_req = 0;
    idle(2);
    chk("unaligned_drained", q_ar.size() + q_rf.size(), 0);
    // async reset during beat 7 of a refill
    push_rf(32'h6000_0000); rf_addr = 32'h6000_0000; r0 = rf_cnt; rf_req = 1;
    for (int i = 0; i < 500 && rf_cnt - r0 < 7; i++) @(negedge clk);
    #2;
    chk("reached_beat7", rf_cnt - r0, 7);
    @(posedge clk); #2;
    arst = 1; rf_req = 0;
    #1;
    chk("mid_rst_free", axi_free, 1);
    chk("mid_rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    chk("mid_rst_outs", {wb_done, rf_done, rf_valid, rf_data, rf_beat, wb_beat}, 0);
    q_ar.delete(); q_rf.delete();
    @(negedge clk); #3;
    arst = 0;
    idle(2);
    rd0 = rf_done_cnt;
    chk("no_resume", {axi_free, axi.arvalid}, 2'b10);
    push_rf(32'h7000_0040); rf_addr = 32'h7000_0040; rf_req = 1;
    wait_done(0, cyc); rf_req = 0;
    chk("restart_cycle", cyc, 34);
    idle(2);
    chk("restart_drained", q_ar.size() + q_rf.size(), 0);
    chk("restart_done_cnt", rf_done_cnt - rd0, 1);
    // random 0-5 cycle stalls everywhere
    rnd = 1; wd0 = wb_done_cnt; rd0 = rf_done_cnt;
    push_wb(32'h8000_00C0); wb_addr = 32'h8000_00C0; wb_req = 1;
    wait_done(1, cyc); wb_req = 0;
    push_rf(32'h9000_0000); rf_addr = 32'h9000_0000; rf_req = 1;
    wait_done(0, cyc); rf_req = 0;
    idle(3);
    chk("rnd_drained", q_aw.size() + q_w.size() + q_ar.size() + q_rf.size(), 0);
    chk("rnd_done_cnt", {wb_done_cnt - wd0, rf_done_cnt - rd0}, {32'd1, 32'd1});
    chk("final_free", axi_free, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
